// File: rtl/trap_pkg.sv
// Shared types and helpers for the trap arbiter: FSM state encoding,
// the default NMI acknowledge vector and a lowest-index priority encoder.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    ASSERT  = 2'd2,
    TRAPPED = 2'd3
  } state_e;

  localparam logic [15:0] DEFAULT_NMI_VECTOR = 16'h0066;
  localparam int          MAX_SRC            = 32;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set(input logic [MAX_SRC-1:0] vec);
    lowest_set = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/trap_arbiter_sync_edge.sv
// Multi-stage synchroniser for an active-low Z80 strobe, with a one-clock
// pulse on the synchronised 1->0 transition. Idles high out of reset.
module z80_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_n_i,
  output logic level_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every stage shift from its pre-edge value.
      sync_q <= {sync_q[STAGES-2:0], async_n_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign fall_o  = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/trap_arbiter.sv
// Latches prioritised trap requests and injects each one into the Z80 as an
// NMI on an opcode-fetch boundary, holding trap_state until supervisor exit.
module trap_arbiter
  import trap_pkg::*;
#(
  parameter int                N_SRC       = 4,
  parameter int                SYNC_STAGES = 2,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] NMI_VECTOR  = ADDR_W'(DEFAULT_NMI_VECTOR),
  parameter int                ACK_TIMEOUT = 255,
  parameter int                CAUSE_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_SRC-1:0]   trap_req,
  input  logic [N_SRC-1:0]   trap_mask,
  input  logic               virtual_enabled,
  input  logic               defer,
  input  logic               m1_n,
  input  logic               iorq_n,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               trap_exit,
  output logic               nmi_n,
  output logic               trap_state,
  output logic [CAUSE_W-1:0] trap_cause,
  output logic               capture_address,
  output logic [N_SRC-1:0]   pending,
  output logic               ack_timeout
);

  localparam logic [N_SRC-1:0] ONE_HOT0 = N_SRC'(1);

  logic m1_level, m1_fall, iorq_level, iorq_fall;

  z80_sync_edge #(.STAGES(SYNC_STAGES)) u_m1_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_n_i (m1_n),
    .level_o   (m1_level),
    .fall_o    (m1_fall)
  );

  z80_sync_edge #(.STAGES(SYNC_STAGES)) u_iorq_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_n_i (iorq_n),
    .level_o   (iorq_level),
    .fall_o    (iorq_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, m1_level, iorq_fall};

  state_e             state_q;
  logic [N_SRC-1:0]   req_q;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   set_vec, clr_vec;
  logic [4:0]         sel;
  logic [7:0]         cnt_q;
  logic               nmi_q, trap_state_q, capture_q, timeout_q;
  logic [CAUSE_W-1:0] cause_q;
  logic               int_ack, fire, nmi_ack;

  // An M1 with IORQ low is an interrupt acknowledge, not an instruction fetch.
  assign int_ack = m1_fall & ~iorq_level;
  assign fire    = (state_q == ARM) & m1_fall & ~int_ack & ~defer
                 & virtual_enabled & (|pending_q);
  assign nmi_ack = m1_fall & (addr == NMI_VECTOR);
  assign sel     = lowest_set(MAX_SRC'(pending_q));
  assign set_vec = trap_req & ~req_q & trap_mask & {N_SRC{virtual_enabled}};
  assign clr_vec = fire ? (ONE_HOT0 << sel) : '0;

  always_comb begin
    // NOTE: pending_d is assigned on every path before use, so no latch is inferred.
    pending_d = (pending_q & ~clr_vec) | set_vec;
    if (!virtual_enabled) pending_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q     <= '0;
      pending_q <= '0;
    end else begin
      req_q     <= trap_req;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      nmi_q        <= 1'b1;
      trap_state_q <= 1'b0;
      cause_q      <= '0;
      capture_q    <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      capture_q <= 1'b0;
      if (trap_exit) timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((|pending_q) && virtual_enabled) state_q <= ARM;
        end
        ARM: begin
          if (pending_q == '0) begin
            state_q <= IDLE;
          end else if (fire) begin
            capture_q    <= 1'b1;
            cause_q      <= CAUSE_W'(sel);
            nmi_q        <= 1'b0;
            trap_state_q <= 1'b1;
            cnt_q        <= 8'(ACK_TIMEOUT);
            state_q      <= ASSERT;
          end
        end
        ASSERT: begin
          // A genuine acknowledge in the final counted cycle still wins over timeout.
          if (nmi_ack) begin
            nmi_q   <= 1'b1;
            state_q <= TRAPPED;
          end else if (cnt_q <= 8'd1) begin
            nmi_q        <= 1'b1;
            timeout_q    <= 1'b1;
            trap_state_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        TRAPPED: begin
          if (trap_exit) begin
            trap_state_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign nmi_n           = nmi_q;
  assign trap_state      = trap_state_q;
  assign trap_cause      = cause_q;
  assign capture_address = capture_q;
  assign pending         = pending_q;
  assign ack_timeout     = timeout_q;

endmodule

// File: tb/tb_trap_arbiter.sv
// Directed bench for trap_arbiter: a cycle-level behavioural model checked on
// every falling clock edge, plus literal expectations at key points.
module tb_trap_arbiter;

  localparam int S   = 2;
  localparam int ACK = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  trap_req = '0, trap_mask = 4'hF;
  logic        virtual_enabled = 1'b1, defer = 1'b0;
  logic        m1_n = 1'b1, iorq_n = 1'b1, trap_exit = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        nmi_n, trap_state, capture_address, ack_timeout;
  logic [1:0]  trap_cause;
  logic [3:0]  pending;

  int checks = 0;
  int errors = 0;

  trap_arbiter #(
    .N_SRC(4), .SYNC_STAGES(S), .ADDR_W(16), .NMI_VECTOR(16'h0066), .ACK_TIMEOUT(ACK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trap_req(trap_req), .trap_mask(trap_mask),
    .virtual_enabled(virtual_enabled), .defer(defer), .m1_n(m1_n), .iorq_n(iorq_n),
    .addr(addr), .trap_exit(trap_exit), .nmi_n(nmi_n), .trap_state(trap_state),
    .trap_cause(trap_cause), .capture_address(capture_address), .pending(pending),
    .ack_timeout(ack_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: traps wait in a pending set, a "phase" tracks where the
  // current trap is, and the synchronisers are plain delay lines of samples.
  typedef enum {P_IDLE, P_ARMED, P_NMI, P_HELD} phase_t;
  phase_t     m_phase = P_IDLE;
  logic [3:0] m_pend = '0, m_prev_req = '0;
  logic [1:0] m_cause = '0;
  logic       m_nmi_n = 1'b1, m_tstate = 1'b0, m_cap = 1'b0, m_tout = 1'b0;
  int         m_left = 0;
  logic [S:0] m1_hist = '1, iorq_hist = '1;

  initial begin
    logic       fall, iack, boundary;
    logic [3:0] new_bits;
    int         pick;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_phase = P_IDLE; m_pend = '0; m_prev_req = '0; m_cause = '0;
        m_nmi_n = 1'b1; m_tstate = 1'b0; m_cap = 1'b0; m_tout = 1'b0;
        m_left = 0; m1_hist = '1; iorq_hist = '1;
      end else begin
        fall      = m1_hist[S] && !m1_hist[S-1];
        iack      = fall && !iorq_hist[S-1];
        m1_hist   = {m1_hist[S-1:0], m1_n};
        iorq_hist = {iorq_hist[S-1:0], iorq_n};
        new_bits  = trap_req & ~m_prev_req & trap_mask & {4{virtual_enabled}};
        m_prev_req = trap_req;
        boundary  = fall && !iack && !defer && virtual_enabled && (m_pend != 0);
        m_cap = 1'b0;
        if (trap_exit) m_tout = 1'b0;
        case (m_phase)
          P_IDLE:  if (m_pend != 0 && virtual_enabled) m_phase = P_ARMED;
          P_ARMED: begin
            if (m_pend == 0) m_phase = P_IDLE;
            else if (boundary) begin
              pick = 0;
              for (int i = 3; i >= 0; i--) if (m_pend[i]) pick = i;
              m_pend[pick] = 1'b0;
              m_cause  = 2'(pick);
              m_cap    = 1'b1;
              m_nmi_n  = 1'b0;
              m_tstate = 1'b1;
              m_left   = ACK;
              m_phase  = P_NMI;
            end
          end
          P_NMI: begin
            if (fall && addr == 16'h0066) begin
              m_nmi_n = 1'b1;
              m_phase = P_HELD;
            end else begin
              m_left--;
              if (m_left == 0) begin
                m_nmi_n = 1'b1; m_tout = 1'b1; m_tstate = 1'b0; m_phase = P_IDLE;
              end
            end
          end
          P_HELD: if (trap_exit) begin m_tstate = 1'b0; m_phase = P_IDLE; end
          default: m_phase = P_IDLE;
        endcase
        m_pend = virtual_enabled ? (m_pend | new_bits) : 4'b0;
      end
    end
  end

  // Packed as {nmi_n, trap_state, trap_cause[1:0], capture_address, pending[3:0], ack_timeout}.
  always @(negedge clk) begin
    check("model_outputs",
          32'({nmi_n, trap_state, trap_cause, capture_address, pending, ack_timeout}),
          32'({m_nmi_n, m_tstate, m_cause, m_cap, m_pend, m_tout}));
  end

  task automatic pulse_req(input logic [3:0] v);
    @(negedge clk) trap_req = v;
    @(negedge clk) trap_req = '0;
  endtask

  task automatic m1_cycle(input logic [15:0] a, input logic iorq);
    @(negedge clk) begin addr = a; m1_n = 1'b0; iorq_n = iorq; end
    repeat (4) @(negedge clk);
    m1_n = 1'b1; iorq_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic exit_pulse();
    @(negedge clk) trap_exit = 1'b1;
    @(negedge clk) trap_exit = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_nmi_n", 32'(nmi_n), 32'd1);
    check("rst_trap_state", 32'(trap_state), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_cause", 32'(trap_cause), 32'd0);
    check("rst_timeout", 32'(ack_timeout), 32'd0);

    // Single trap on source 2, with exact capture latency after /M1 falls.
    pulse_req(4'b0100);
    check("single_pending", 32'(pending), 32'h4);
    repeat (2) @(negedge clk);
    addr = 16'h1234; m1_n = 1'b0; iorq_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("single_capture_early", 32'(capture_address), 32'd0);
    @(posedge clk);
    #1;
    check("single_capture", 32'(capture_address), 32'd1);
    check("single_nmi_low", 32'(nmi_n), 32'd0);
    check("single_cause", 32'(trap_cause), 32'd2);
    check("single_pending_clr", 32'(pending), 32'd0);
    @(negedge clk) m1_n = 1'b1;
    m1_cycle(16'h0066, 1'b1);
    check("single_nmi_release", 32'(nmi_n), 32'd1);
    check("single_trapped", 32'(trap_state), 32'd1);
    exit_pulse();
    check("single_exit", 32'(trap_state), 32'd0);

    // Simultaneous requests: lower index is serviced first.
    pulse_req(4'b1010);
    check("prio_pending", 32'(pending), 32'hA);
    repeat (2) @(negedge clk);
    m1_cycle(16'h1234, 1'b1);
    check("prio_cause1", 32'(trap_cause), 32'd1);
    check("prio_pending_left", 32'(pending), 32'h8);
    m1_cycle(16'h0066, 1'b1);
    exit_pulse();
    m1_cycle(16'h1234, 1'b1);
    check("prio_cause3", 32'(trap_cause), 32'd3);
    check("prio_nmi_low", 32'(nmi_n), 32'd0);
    m1_cycle(16'h0066, 1'b1);
    exit_pulse();

    // Interrupt-acknowledge and deferred M1 cycles are not boundaries.
    pulse_req(4'b0001);
    repeat (2) @(negedge clk);
    m1_cycle(16'h1234, 1'b0);
    check("iack_no_nmi", 32'(nmi_n), 32'd1);
    check("iack_pending", 32'(pending), 32'h1);
    defer = 1'b1;
    m1_cycle(16'h1234, 1'b1);
    defer = 1'b0;
    check("defer_no_nmi", 32'(nmi_n), 32'd1);
    m1_cycle(16'h1234, 1'b1);
    check("clean_nmi", 32'(nmi_n), 32'd0);
    check("clean_cause", 32'(trap_cause), 32'd0);
    m1_cycle(16'h0066, 1'b1);
    exit_pulse();

    // Acknowledge never arrives: NMI released after exactly ACK cycles.
    pulse_req(4'b1000);
    repeat (2) @(negedge clk);
    addr = 16'h2000; m1_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("to_capture", 32'(capture_address), 32'd1);
    @(negedge clk) m1_n = 1'b1;
    repeat (ACK - 1) @(posedge clk);
    #1 check("to_nmi_still_low", 32'(nmi_n), 32'd0);
    @(posedge clk);
    #1;
    check("to_nmi_released", 32'(nmi_n), 32'd1);
    check("to_flag", 32'(ack_timeout), 32'd1);
    check("to_state", 32'(trap_state), 32'd0);
    exit_pulse();
    check("to_flag_cleared", 32'(ack_timeout), 32'd0);

    // Masking and global disable.
    trap_mask = 4'h0;
    pulse_req(4'b1111);
    check("mask_pending", 32'(pending), 32'd0);
    trap_mask = 4'hF;
    pulse_req(4'b0001);
    check("ven_pending_set", 32'(pending), 32'h1);
    virtual_enabled = 1'b0;
    @(posedge clk);
    #1 check("ven_pending_clr", 32'(pending), 32'd0);
    m1_cycle(16'h1234, 1'b1);
    pulse_req(4'b0010);
    check("ven_block", 32'(pending), 32'd0);
    check("ven_no_nmi", 32'(nmi_n), 32'd1);
    virtual_enabled = 1'b1;

    // Asynchronous reset in the middle of ASSERT.
    pulse_req(4'b0010);
    repeat (2) @(negedge clk);
    m1_cycle(16'h1234, 1'b1);
    check("rst_mid_nmi_low", 32'(nmi_n), 32'd0);
    pulse_req(4'b0100);
    check("rst_mid_pending", 32'(pending), 32'h4);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_nmi_n", 32'(nmi_n), 32'd1);
    check("arst_trap_state", 32'(trap_state), 32'd0);
    check("arst_pending", 32'(pending), 32'd0);
    check("arst_cause", 32'(trap_cause), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
